pll_lock_monitor: RTL and testbench

Supervises the audio/video PLL from the always-running reference clock: drives the PLL's reset input, watches its asynchronous `locked` flag, and releases a single system reset to the core only after lock has been stable for a programmable time. On lock timeout or loss of lock it re-resets the PLL and re-holds the core in reset. It sits between the board reference clock and the PLL wrapper, and its system-reset output feeds the per-domain reset synchronizers of the 48/24/6 MHz core logic.

---
 rtl/pll_lock_monitor_if.sv | 52 +++++
 rtl/pll_lock_monitor.sv | 186 ++++++++++++++++++
 tb/tb_pll_lock_monitor.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_monitor_if.sv
// ---------------------------------------------------------------------------
// pll_lock_monitor_if
//
// Purpose:
//   Groups the signals exchanged between the PLL lock monitor and the
//   surrounding system (PLL wrapper and core reset synchronizers) into one
//   bundle. The clock and reset are not part of the bundle; they stay as
//   plain ports on the monitor.
//
// Parameters:
//   CNT_W       width of the statistics counters
//
// Signals:
//   pll_locked  PLL lock flag, asynchronous to the reference clock
//   pll_rst     reset to the PLL, active-high
//   sys_reset   core reset, active-high
//   state       monitor state: 0=PLLRST, 1=WAIT_LOCK, 2=STABLE, 3=RUN
//   retry_cnt   lock-timeout retries, saturating
//   lost_cnt    losses of lock from RUN, saturating
//
// Modports:
//   master      the monitor side: samples pll_locked, drives everything else
//   slave       the PLL / core side: drives pll_locked, observes the rest
// ---------------------------------------------------------------------------
interface pll_lock_monitor_if #(
    parameter int CNT_W = 8
);
    logic             pll_locked;
    logic             pll_rst;
    logic             sys_reset;
    logic [1:0]       state;
    logic [CNT_W-1:0] retry_cnt;
    logic [CNT_W-1:0] lost_cnt;

    modport master (
        input  pll_locked,
        output pll_rst,
        output sys_reset,
        output state,
        output retry_cnt,
        output lost_cnt
    );

    modport slave (
        output pll_locked,
        input  pll_rst,
        input  sys_reset,
        input  state,
        input  retry_cnt,
        input  lost_cnt
    );
endinterface

// File: rtl/pll_lock_monitor.sv
// ---------------------------------------------------------------------------
// pll_lock_monitor
//
// Purpose:
//   Supervises the audio/video PLL from the always-running reference clock.
//   It pulses the PLL reset, waits for the PLL to report lock, requires the
//   lock flag to stay up for a programmable number of cycles, and only then
//   releases the system reset to the core. A lock timeout or a loss of lock
//   while running sends the block back to resetting the PLL, and the core is
//   held in reset again on the very same edge.
//
// Parameters:
//   SYNC_STAGES     flops in the pll_locked synchronizer (>= 2)
//   PLL_RST_CYCLES  refclk cycles pll_rst is held per attempt (>= 2)
//   LOCK_TIMEOUT    refclk cycles to wait for lock before retrying (>= 2)
//   STABLE_CYCLES   consecutive locked cycles before releasing the core (>= 2)
//   CNT_W           width of the statistics counters
//
// Ports:
//   refclk          reference clock, the only clock in this block
//   rst             asynchronous active-high reset
//   mon             pll_lock_monitor_if.master bundle:
//                     pll_locked (in), pll_rst, sys_reset, state,
//                     retry_cnt, lost_cnt (out)
//
// Build options:
//   PLL_MON_STATS_EN  when defined, retry_cnt and lost_cnt are real saturating
//                     counters; when undefined they read constant zero and no
//                     counter flops are built. The FSM is identical either way.
// ---------------------------------------------------------------------------
module pll_lock_monitor #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int CNT_W          = 8
) (
    input  logic                  refclk,
    input  logic                  rst,
    pll_lock_monitor_if.master    mon
);

    // State encoding is fixed because it is visible on the state output.
    localparam logic [1:0] ST_PLLRST    = 2'd0;
    localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] ST_STABLE    = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    // The shared cycle counter only has to reach the largest terminal value.
    localparam int MAX_A    = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_T    = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CNT_BITS = $clog2(MAX_T);

    localparam logic [CNT_BITS-1:0] PLL_RST_LAST = CNT_BITS'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] TIMEOUT_LAST = CNT_BITS'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_BITS-1:0] STABLE_LAST  = CNT_BITS'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;

    logic [1:0]             state_q;
    logic [1:0]             next_state;
    logic [CNT_BITS-1:0]    cnt_q;
    logic [CNT_BITS-1:0]    cnt_next;

    logic                   pll_rst_q;
    logic                   sys_reset_q;

    // Lock flag synchronizer. The PLL raises locked on its own timebase, so
    // it is resampled through a plain shift chain before the FSM looks at it.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], mon.pll_locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Next-state and counter decode. The counter restarts from zero whenever
    // the state changes, so every state measures its own dwell time. In RUN
    // there is nothing to time and the counter just holds.
    always_comb begin
        next_state = state_q;
        cnt_next   = cnt_q;

        case (state_q)
            ST_PLLRST: begin
                if (cnt_q == PLL_RST_LAST) begin
                    next_state = ST_WAIT_LOCK;
                end else begin
                    cnt_next = cnt_q + 1'b1;
                end
            end

            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    next_state = ST_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    next_state = ST_PLLRST;
                end else begin
                    cnt_next = cnt_q + 1'b1;
                end
            end

            ST_STABLE: begin
                // A dropout here only restarts the lock wait; the PLL is not
                // reset and no statistic is recorded.
                if (!locked_s) begin
                    next_state = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    next_state = ST_RUN;
                end else begin
                    cnt_next = cnt_q + 1'b1;
                end
            end

            default: begin
                if (!locked_s) begin
                    next_state = ST_PLLRST;
                end
            end
        endcase

        if (next_state != state_q) begin
            cnt_next = '0;
        end
    end

    // State, counter and the two reset outputs are all registered from the
    // next-state decode, so both resets move on the same edge as the state
    // change and never glitch. Reset parks everything in PLLRST with both
    // resets asserted.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_PLLRST;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
        end else begin
            state_q     <= next_state;
            cnt_q       <= cnt_next;
            pll_rst_q   <= (next_state == ST_PLLRST);
            sys_reset_q <= (next_state != ST_RUN);
        end
    end

    assign mon.state     = state_q;
    assign mon.pll_rst   = pll_rst_q;
    assign mon.sys_reset = sys_reset_q;

`ifdef PLL_MON_STATS_EN
    logic             retry_inc;
    logic             lost_inc;
    logic [CNT_W-1:0] retry_q;
    logic [CNT_W-1:0] lost_q;

    // A retry is a timeout out of WAIT_LOCK; a loss is a drop out of RUN.
    // Both are the only ways into PLLRST from their respective states.
    assign retry_inc = (state_q == ST_WAIT_LOCK) && (next_state == ST_PLLRST);
    assign lost_inc  = (state_q == ST_RUN)       && (next_state == ST_PLLRST);

    // Saturating statistics counters; only the block reset clears them.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            retry_q <= '0;
            lost_q  <= '0;
        end else begin
            if (retry_inc && (retry_q != {CNT_W{1'b1}})) begin
                retry_q <= retry_q + 1'b1;
            end
            if (lost_inc && (lost_q != {CNT_W{1'b1}})) begin
                lost_q <= lost_q + 1'b1;
            end
        end
    end

    assign mon.retry_cnt = retry_q;
    assign mon.lost_cnt  = lost_q;
`else
    assign mon.retry_cnt = {CNT_W{1'b0}};
    assign mon.lost_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_monitor
//
// Purpose:
//   Directed self-checking bench for pll_lock_monitor with small timing
//   parameters (SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=20,
//   STABLE_CYCLES=8, CNT_W=8). Expected statistics values follow the
//   PLL_MON_STATS_EN build option: real counts when defined, zero otherwise.
// ---------------------------------------------------------------------------
module tb_pll_lock_monitor;

    localparam int SYNC_STAGES    = 2;
    localparam int PLL_RST_CYCLES = 4;
    localparam int LOCK_TIMEOUT   = 20;
    localparam int STABLE_CYCLES  = 8;
    localparam int CNT_W          = 8;

`ifdef PLL_MON_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic refclk = 1'b0;
    logic rst    = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    pll_lock_monitor_if #(.CNT_W(CNT_W)) mon_if ();

    pll_lock_monitor #(
        .SYNC_STAGES    (SYNC_STAGES),
        .PLL_RST_CYCLES (PLL_RST_CYCLES),
        .LOCK_TIMEOUT   (LOCK_TIMEOUT),
        .STABLE_CYCLES  (STABLE_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .mon    (mon_if)
    );

    // 10 time-unit reference clock.
    always #5 refclk = ~refclk;

    // Advance n rising edges and settle 1 unit past the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic locked);
        mon_if.pll_locked = locked;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Expected statistic value for this build.
    function automatic logic [31:0] stat(input int n);
        return STATS_EN ? 32'(n) : 32'd0;
    endfunction

    task automatic checkCore(input string tag, input int st, input logic pr, input logic sr);
        checkOutput({tag, ".state"},     32'(mon_if.state),     32'(st));
        checkOutput({tag, ".pll_rst"},   32'(mon_if.pll_rst),   32'(pr));
        checkOutput({tag, ".sys_reset"}, 32'(mon_if.sys_reset), 32'(sr));
    endtask

    task automatic checkStats(input string tag, input int retries, input int losses);
        checkOutput({tag, ".retry_cnt"}, 32'(mon_if.retry_cnt), stat(retries));
        checkOutput({tag, ".lost_cnt"},  32'(mon_if.lost_cnt),  stat(losses));
    endtask

    initial begin
        applyStimulus(1'b1);
        rst = 1'b1;
        tick(3);

        // Reset state.
        checkCore("reset", 0, 1'b1, 1'b1);
        checkStats("reset", 0, 0);

        // Power-up with lock present from the start.
        $display("[TB] power-up with constant lock");
        rst = 1'b0;
        tick(3);
        checkCore("pu_e3", 0, 1'b1, 1'b1);
        tick(1);
        checkCore("pu_e4", 1, 1'b0, 1'b1);
        tick(1);
        checkCore("pu_e5", 2, 1'b0, 1'b1);
        tick(7);
        checkCore("pu_e12", 2, 1'b0, 1'b1);
        tick(1);
        checkCore("pu_e13", 3, 1'b0, 1'b0);

        // Loss of lock in RUN, then relock.
        $display("[TB] loss of lock in RUN");
        applyStimulus(1'b0);
        tick(2);
        checkCore("loss_e2", 3, 1'b0, 1'b0);
        tick(1);
        checkCore("loss_e3", 0, 1'b1, 1'b1);
        checkStats("loss_e3", 0, 1);
        applyStimulus(1'b1);
        tick(4);
        checkCore("relock_e4", 1, 1'b0, 1'b1);
        tick(1);
        checkCore("relock_e5", 2, 1'b0, 1'b1);
        tick(7);
        checkCore("relock_e12", 2, 1'b0, 1'b1);
        tick(1);
        checkCore("relock_e13", 3, 1'b0, 1'b0);
        checkStats("relock_e13", 0, 1);

        // Dropout during STABLE restarts the lock wait without a PLL reset.
        $display("[TB] dropout during STABLE");
        applyStimulus(1'b0);
        tick(3);
        checkCore("loss2_e3", 0, 1'b1, 1'b1);
        checkStats("loss2_e3", 0, 2);
        applyStimulus(1'b1);
        tick(5);
        checkCore("glitch_e5", 2, 1'b0, 1'b1);
        tick(3);
        applyStimulus(1'b0);
        tick(2);
        checkCore("glitch_e10", 2, 1'b0, 1'b1);
        tick(1);
        checkCore("glitch_e11", 1, 1'b0, 1'b1);
        checkStats("glitch_e11", 0, 2);
        applyStimulus(1'b1);
        tick(2);
        checkCore("glitch_e13", 1, 1'b0, 1'b1);
        tick(1);
        checkCore("glitch_e14", 2, 1'b0, 1'b1);
        tick(7);
        checkCore("glitch_e21", 2, 1'b0, 1'b1);
        tick(1);
        checkCore("glitch_e22", 3, 1'b0, 1'b0);
        checkStats("glitch_e22", 0, 2);

        // Asynchronous reset from RUN.
        $display("[TB] async reset from RUN, then no lock");
        rst = 1'b1;
        #1;
        checkCore("arst_run", 0, 1'b1, 1'b1);
        checkStats("arst_run", 0, 0);
        applyStimulus(1'b0);
        tick(2);
        rst = 1'b0;

        // Lock never arrives: 20 cycles waiting, 4 cycles in PLL reset.
        tick(4);
        checkCore("nolock_e4", 1, 1'b0, 1'b1);
        tick(19);
        checkCore("nolock_e23", 1, 1'b0, 1'b1);
        checkStats("nolock_e23", 0, 0);
        tick(1);
        checkCore("nolock_e24", 0, 1'b1, 1'b1);
        checkStats("nolock_e24", 1, 0);
        tick(3);
        checkCore("nolock_e27", 0, 1'b1, 1'b1);
        tick(1);
        checkCore("nolock_e28", 1, 1'b0, 1'b1);
        tick(20);
        checkCore("nolock_e48", 0, 1'b1, 1'b1);
        checkStats("nolock_e48", 2, 0);
        tick(24);
        checkStats("nolock_e72", 3, 0);
        tick(8);
        checkCore("nolock_e80", 1, 1'b0, 1'b1);

        // Asynchronous reset in WAIT_LOCK clears the retry count.
        rst = 1'b1;
        #1;
        checkCore("arst_wait", 0, 1'b1, 1'b1);
        checkStats("arst_wait", 0, 0);
        tick(2);

        // Saturation of the retry counter.
        $display("[TB] retry counter saturation");
        rst = 1'b0;
        tick(24 * 254);
        checkStats("sat_254", 254, 0);
        tick(24);
        checkStats("sat_255", 255, 0);
        tick(24 * 6);
        checkStats("sat_260", 255, 0);
        checkCore("sat_260", 0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
